// File: rtl/avg_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avg_video_pkg
// Desc     : Shared constants and types for the AVG video path (rasterizer
//            and framebuffer writer).
// Revision : 1.0 - initial release
// ============================================================================
package avg_video_pkg;

   localparam int COORD_W  = 10;   // coordinate width, 0..1023
   localparam int COLOR_W  = 3;    // bit0 R, bit1 G, bit2 B
   localparam int FB_WIDTH = 720;  // visible framebuffer width

   // Line rasterizer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } rast_state_t;

endpackage
`default_nettype wire

// File: rtl/avg_line_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : avg_line_rasterizer
// Desc     : Converts vector draw commands into single-pixel framebuffer
//            writes using integer Bresenham stepping, one pixel per
//            un-stalled cycle, with backpressure from the pixel writer.
// Revision : 1.0 - initial release
// ============================================================================
module avg_line_rasterizer #(
   parameter int COORD_W = avg_video_pkg::COORD_W,
   parameter int COLOR_W = avg_video_pkg::COLOR_W
) (
   input  logic               clk_sys,
   input  logic               reset_l,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic [COLOR_W-1:0] cmd_color,
   input  logic               pixel_stall,
   output logic [COORD_W-1:0] pixel_x_o,
   output logic [COORD_W-1:0] pixel_y_o,
   output logic [COLOR_W-1:0] pixel_c_o,
   output logic               pixel_write,
   output logic               busy,
   output logic               line_done
);
   import avg_video_pkg::*;

   // err spans -(2^COORD_W - 1) .. +(2^COORD_W - 1) plus one step of headroom
   localparam int C_ERR_W = COORD_W + 2;
   localparam int C_E2_W  = COORD_W + 3;

   rast_state_t                r_state;
   logic [COORD_W-1:0]         r_x0, r_y0, r_x1, r_y1;
   logic [COLOR_W-1:0]         r_color;
   logic [COORD_W-1:0]         r_cur_x, r_cur_y;
   logic [COORD_W-1:0]         r_dx;
   logic signed [C_ERR_W-1:0]  r_dy;        // always <= 0
   logic signed [C_ERR_W-1:0]  r_err;
   logic                       r_sx_neg, r_sy_neg;

   // Setup-time deltas and directions from the latched endpoints
   logic                       w_x_fwd, w_y_fwd;
   logic [COORD_W-1:0]         w_dx, w_ady;

   assign w_x_fwd = (r_x1 >= r_x0);
   assign w_y_fwd = (r_y1 >= r_y0);
   assign w_dx    = w_x_fwd ? (r_x1 - r_x0) : (r_x0 - r_x1);
   assign w_ady   = w_y_fwd ? (r_y1 - r_y0) : (r_y0 - r_y1);

   // Per-pixel step decision, both compares use the pre-update err
   logic signed [C_E2_W-1:0]   w_e2, w_dy_ext, w_dx_ext;
   logic signed [C_ERR_W-1:0]  w_dx_err, w_err_nxt;
   logic                       w_step_x, w_step_y, w_at_end;
   logic [COORD_W-1:0]         w_x_nxt, w_y_nxt;

   assign w_e2      = {r_err, 1'b0};
   assign w_dy_ext  = {r_dy[C_ERR_W-1], r_dy};
   assign w_dx_ext  = {3'b000, r_dx};
   assign w_step_x  = (w_e2 >= w_dy_ext);
   assign w_step_y  = (w_e2 <= w_dx_ext);
   assign w_dx_err  = {2'b00, r_dx};
   assign w_err_nxt = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? w_dx_err : '0);
   assign w_at_end  = (r_cur_x == r_x1) && (r_cur_y == r_y1);
   assign w_x_nxt   = !w_step_x ? r_cur_x :
                      (r_sx_neg ? (r_cur_x - 1'b1) : (r_cur_x + 1'b1));
   assign w_y_nxt   = !w_step_y ? r_cur_y :
                      (r_sy_neg ? (r_cur_y - 1'b1) : (r_cur_y + 1'b1));

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);

   // Control FSM with registered pixel/done outputs and the Bresenham datapath
   always_ff @(posedge clk_sys or negedge reset_l) begin
      if (!reset_l) begin
         r_state     <= ST_IDLE;
         r_x0        <= '0;
         r_y0        <= '0;
         r_x1        <= '0;
         r_y1        <= '0;
         r_color     <= '0;
         r_cur_x     <= '0;
         r_cur_y     <= '0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_err       <= '0;
         r_sx_neg    <= 1'b0;
         r_sy_neg    <= 1'b0;
         pixel_x_o   <= '0;
         pixel_y_o   <= '0;
         pixel_c_o   <= '0;
         pixel_write <= 1'b0;
         line_done   <= 1'b0;
      end else begin
         pixel_write <= 1'b0;
         line_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_x0    <= cmd_x0;
                  r_y0    <= cmd_y0;
                  r_x1    <= cmd_x1;
                  r_y1    <= cmd_y1;
                  r_color <= cmd_color;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_dx     <= w_dx;
               r_dy     <= '0 - {2'b00, w_ady};
               r_err    <= {2'b00, w_dx} - {2'b00, w_ady};
               r_sx_neg <= !w_x_fwd;
               r_sy_neg <= !w_y_fwd;
               r_cur_x  <= r_x0;
               r_cur_y  <= r_y0;
               // A zero colour is a blank (move-only) vector
               r_state  <= (r_color == '0) ? ST_DONE : ST_DRAW;
            end
            ST_DRAW: begin
               if (!pixel_stall) begin
                  pixel_x_o   <= r_cur_x;
                  pixel_y_o   <= r_cur_y;
                  pixel_c_o   <= r_color;
                  pixel_write <= 1'b1;
                  if (w_at_end) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_err   <= w_err_nxt;
                     r_cur_x <= w_x_nxt;
                     r_cur_y <= w_y_nxt;
                  end
               end
            end
            ST_DONE: begin
               line_done <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avg_line_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_avg_line_rasterizer
// Desc     : Self-checking bench for avg_line_rasterizer: directed lines
//            against an integer line model plus literal pixel expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avg_line_rasterizer;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk_sys = 1'b0;
   logic       reset_l = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [2:0] cmd_color = '0;
   logic       pixel_stall = 1'b0;
   logic [9:0] pixel_x_o, pixel_y_o;
   logic [2:0] pixel_c_o;
   logic       pixel_write, busy, line_done;

   int   total = 0;
   int   bad = 0;
   int   writes_seen = 0;
   pix_t exp_q[$];
   pix_t gen_q[$];

   avg_line_rasterizer dut (
      .clk_sys     (clk_sys),
      .reset_l     (reset_l),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x0      (cmd_x0),
      .cmd_y0      (cmd_y0),
      .cmd_x1      (cmd_x1),
      .cmd_y1      (cmd_y1),
      .cmd_color   (cmd_color),
      .pixel_stall (pixel_stall),
      .pixel_x_o   (pixel_x_o),
      .pixel_y_o   (pixel_y_o),
      .pixel_c_o   (pixel_c_o),
      .pixel_write (pixel_write),
      .busy        (busy),
      .line_done   (line_done)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Reference line: every pixel from start to end inclusive, plain integers
   task automatic gen_line(input int x0, input int y0, input int x1, input int y1, input int c);
      int dx, dy, sx, sy, err, e2, x, y;
      pix_t p;
      gen_q.delete();
      if (c == 0) return;
      dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
      dy  = (y1 >= y0) ? y0 - y1 : y1 - y0;
      sx  = (x1 >= x0) ? 1 : -1;
      sy  = (y1 >= y0) ? 1 : -1;
      err = dx + dy;
      x   = x0;
      y   = y0;
      for (int guard = 0; guard < 2100; guard++) begin
         p.x = x[9:0];
         p.y = y[9:0];
         p.c = c[2:0];
         gen_q.push_back(p);
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endtask

   // Scoreboard: every observed write must be the next expected pixel
   always @(negedge clk_sys) begin
      if (reset_l && pixel_write) begin
         pix_t p;
         writes_seen++;
         if (exp_q.size() == 0) begin
            chk("extra_write", 1, 0);
         end else begin
            p = exp_q.pop_front();
            chk("pix_x", int'(pixel_x_o), int'(p.x));
            chk("pix_y", int'(pixel_y_o), int'(p.y));
            chk("pix_c", int'(pixel_c_o), int'(p.c));
         end
      end
   end

   task automatic send(input int x0, input int y0, input int x1, input int y1, input int c);
      @(negedge clk_sys);
      cmd_x0    = x0[9:0];
      cmd_y0    = y0[9:0];
      cmd_x1    = x1[9:0];
      cmd_y1    = y1[9:0];
      cmd_color = c[2:0];
      cmd_valid = 1'b1;
      chk("ready_idle", int'(cmd_ready), 1);
      @(posedge clk_sys);
      #1;
      cmd_valid = 1'b0;
      cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
   endtask

   // Runs the line currently in gen_q; st_len stall cycles start at negedge st_start
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input int c, input int st_start, input int st_len);
      int n, first_n, done_n, npix, limit;
      logic [9:0] hx, hy;
      npix = gen_q.size();
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      writes_seen = 0;
      hx = '0; hy = '0;
      send(x0, y0, x1, y1, c);
      n = 0; first_n = -1; done_n = -1;
      limit = npix + st_len + 20;
      while (n < limit && done_n < 0) begin
         @(negedge clk_sys);
         n++;
         if (pixel_write && first_n < 0) first_n = n;
         if (line_done) done_n = n;
         if (n == 2) begin
            chk("busy_mid", int'(busy), 1);
            chk("ready_mid", int'(cmd_ready), 0);
         end
         if (st_len > 0 && n == st_start) begin hx = pixel_x_o; hy = pixel_y_o; end
         if (st_len > 0 && n > st_start && n <= st_start + st_len) begin
            chk("stall_nowrite", int'(pixel_write), 0);
            chk("stall_hold_x", int'(pixel_x_o), int'(hx));
            chk("stall_hold_y", int'(pixel_y_o), int'(hy));
         end
         pixel_stall = (st_len > 0 && n >= st_start && n < st_start + st_len);
      end
      pixel_stall = 1'b0;
      chk("done_seen", (done_n > 0) ? 1 : 0, 1);
      chk("first_write_cyc", first_n, (npix > 0) ? 3 : -1);
      chk("done_cyc", done_n, 3 + npix + st_len);
      @(negedge clk_sys);
      chk("done_pulse_1cyc", int'(line_done), 0);
      chk("ready_after", int'(cmd_ready), 1);
      chk("busy_after", int'(busy), 0);
      chk("write_count", writes_seen, npix);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int found;
      // Reset state
      #12;
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(line_done), 0);
      chk("rst_write", int'(pixel_write), 0);
      chk("rst_x", int'(pixel_x_o), 0);
      chk("rst_y", int'(pixel_y_o), 0);
      chk("rst_c", int'(pixel_c_o), 0);
      @(negedge clk_sys);
      reset_l = 1'b1;

      // Horizontal line, pinned literally
      gen_line(10, 5, 14, 5, 3);
      chk("lit_h_count", gen_q.size(), 5);
      foreach (gen_q[i]) begin
         chk("lit_h_x", int'(gen_q[i].x), 10 + i);
         chk("lit_h_y", int'(gen_q[i].y), 5);
      end
      run_line(10, 5, 14, 5, 3, 0, 0);

      // Steep line, pinned literally
      begin
         int lx[8] = '{0, 0, 1, 1, 1, 1, 2, 2};
         gen_line(0, 0, 2, 7, 7);
         chk("lit_s_count", gen_q.size(), 8);
         foreach (gen_q[i]) begin
            chk("lit_s_x", int'(gen_q[i].x), lx[i]);
            chk("lit_s_y", int'(gen_q[i].y), i);
         end
      end
      run_line(0, 0, 2, 7, 7, 0, 0);

      // Single point
      gen_line(100, 200, 100, 200, 1);
      chk("lit_pt_count", gen_q.size(), 1);
      run_line(100, 200, 100, 200, 1, 0, 0);

      // Blank vector
      gen_line(5, 5, 50, 60, 0);
      chk("lit_blank_count", gen_q.size(), 0);
      run_line(5, 5, 50, 60, 0, 0, 0);

      // Full-range reverse diagonal
      gen_line(1023, 1023, 0, 0, 5);
      chk("lit_d_count", gen_q.size(), 1024);
      chk("lit_d_last_x", int'(gen_q[1023].x), 0);
      chk("lit_d_mid_y", int'(gen_q[23].y), 1000);
      run_line(1023, 1023, 0, 0, 5, 0, 0);

      // Shallow line in the negative-x direction
      gen_line(20, 30, 3, 25, 6);
      run_line(20, 30, 3, 25, 6, 0, 0);

      // Four stall cycles mid-line
      gen_line(0, 0, 9, 0, 2);
      run_line(0, 0, 9, 0, 2, 4, 4);

      // Reset at the third pixel
      gen_line(0, 0, 9, 0, 4);
      foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      send(0, 0, 9, 0, 4);
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge clk_sys);
         if (pixel_write && pixel_x_o == 10'd2) found = 1;
      end
      chk("rst3_reached", found, 1);
      #2 reset_l = 1'b0;
      #1;
      chk("arst_write", int'(pixel_write), 0);
      chk("arst_x", int'(pixel_x_o), 0);
      chk("arst_y", int'(pixel_y_o), 0);
      chk("arst_c", int'(pixel_c_o), 0);
      chk("arst_busy", int'(busy), 0);
      exp_q.delete();
      repeat (3) begin
         @(negedge clk_sys);
         chk("arst_no_done", int'(line_done), 0);
      end
      reset_l = 1'b1;
      repeat (3) begin
         @(negedge clk_sys);
         chk("post_rst_ready", int'(cmd_ready), 1);
         chk("post_rst_no_done", int'(line_done), 0);
         chk("post_rst_no_write", int'(pixel_write), 0);
      end

      // Recovery after reset
      gen_line(7, 3, 4, 4, 1);
      run_line(7, 3, 4, 4, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
